reg_bank_multiport: RTL and testbench

//  Parametrised register bank: one write port, NUM_RD independent registered read ports,
//  and a burst-dump engine that streams a contiguous, wrapping address range over a

---
 rtl/reg_bank_multiport.sv | 148 ++++++++++++++
 tb/tb_reg_bank_multiport.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_multiport.sv
// reg_bank_multiport
//   Register bank with one write port, NUM_RD registered read ports and a
//   burst-dump engine that streams a contiguous, wrapping address range over
//   a valid/ready interface. Storage is shared by all paths with no stalls.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wr_en/addr/data     write port; out-of-range addresses are dropped
//   rd_addr / rd_data   packed read ports, port p at [p*W +: W], latency 1,
//                       same-cycle write is forwarded, out-of-range reads 0
//   dump_start/base/len burst request, sampled only while idle
//   dump_valid/ready    beat handshake
//   dump_data/addr/last beat payload, held stable while stalled
//   dump_busy           engine is streaming
module reg_bank_multiport #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     dump_start,
    input  logic [ADDR_W-1:0]        dump_base,
    input  logic [ADDR_W:0]          dump_len,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [DATA_W-1:0]        dump_data,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic                     dump_last,
    output logic                     dump_busy
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_X   = (ADDR_W+1)'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                   state;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_next;
    logic [NUM_RD*DATA_W-1:0] rd_data_p1;
    logic [ADDR_W:0]          len_q;
    logic [ADDR_W:0]          beat_q;     // index of the next beat to load
    logic                     start_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    // Register contents as seen this cycle, with the pending write forwarded.
    function automatic logic [DATA_W-1:0] fetch(input logic [ADDR_W-1:0] a);
        if (!in_range(a))
            return '0;
        if (wr_en && (wr_addr == a))
            return wr_data;
        return mem[a];
    endfunction

    // Increment modulo DEPTH, done one bit wider so non-power-of-two depths wrap.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + ONE_X;
        if (s >= DEPTH_X)
            s = s - DEPTH_X;
        return s[ADDR_W-1:0];
    endfunction

    assign start_ok = dump_start && (dump_len != '0) && (dump_len <= DEPTH_X)
                      && in_range(dump_base);

    // Storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en && in_range(wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read ports: stage p0 is the combinational fetch, p1 the output register
    always_comb begin
        rd_next = '0;
        for (int p = 0; p < NUM_RD; p++)
            rd_next[p*DATA_W +: DATA_W] = fetch(rd_addr[p*ADDR_W +: ADDR_W]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_p1 <= '0;
        else
            rd_data_p1 <= rd_next;
    end

    assign rd_data = rd_data_p1;

    // Dump engine: the output register is the beat currently offered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            beat_q     <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
            dump_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= STREAM;
                        len_q      <= dump_len;
                        beat_q     <= ONE_X;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                        dump_addr  <= dump_base;
                        dump_data  <= fetch(dump_base);
                        dump_last  <= (dump_len == ONE_X);
                    end
                end
                STREAM: begin
                    if (dump_valid && dump_ready) begin
                        if (dump_last) begin
                            state      <= IDLE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_last  <= 1'b0;
                        end else begin
                            dump_addr <= wrap_inc(dump_addr);
                            dump_data <= fetch(wrap_inc(dump_addr));
                            dump_last <= (beat_q == (len_q - ONE_X));
                            beat_q    <= beat_q + ONE_X;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_multiport.sv
module tb_reg_bank_multiport;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int NUM_RD = 2;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                     clk;
    logic                     rst;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     dump_start;
    logic [ADDR_W-1:0]        dump_base;
    logic [ADDR_W:0]          dump_len;
    logic                     dump_valid;
    logic                     dump_ready;
    logic [DATA_W-1:0]        dump_data;
    logic [ADDR_W-1:0]        dump_addr;
    logic                     dump_last;
    logic                     dump_busy;

    int checks = 0;
    int errors = 0;

    reg_bank_multiport #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_addr(dump_addr), .dump_last(dump_last), .dump_busy(dump_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] e_rd  [NUM_RD];
    logic              e_valid, e_busy, e_last;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    int                q_addr [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] peek(input int a);
        if (a >= DEPTH) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    // One clock: advance the model with the current inputs, clock the DUT, compare.
    task automatic tick();
        int a;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            for (int p = 0; p < NUM_RD; p++) e_rd[p] = '0;
            q_addr.delete();
            e_valid = 0; e_busy = 0; e_last = 0; e_addr = '0; e_data = '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++)
                e_rd[p] = peek(int'(rd_addr[p*ADDR_W +: ADDR_W]));
            if (e_busy) begin
                if (dump_ready) begin
                    if (q_addr.size() == 0) begin
                        e_busy = 0; e_valid = 0; e_last = 0;
                    end else begin
                        a = q_addr.pop_front();
                        e_addr = ADDR_W'(a);
                        e_data = peek(a);
                        e_last = (q_addr.size() == 0);
                    end
                end
            end else if (dump_start && dump_len >= 1 && int'(dump_len) <= DEPTH
                         && int'(dump_base) < DEPTH) begin
                for (int k = 0; k < int'(dump_len); k++)
                    q_addr.push_back((int'(dump_base) + k) % DEPTH);
                a = q_addr.pop_front();
                e_addr = ADDR_W'(a);
                e_data = peek(a);
                e_last = (q_addr.size() == 0);
                e_valid = 1; e_busy = 1;
            end
            if (wr_en && int'(wr_addr) < DEPTH) m_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NUM_RD; p++)
            chk($sformatf("rd%0d", p), 32'(rd_data[p*DATA_W +: DATA_W]), 32'(e_rd[p]));
        chk("valid", 32'(dump_valid), 32'(e_valid));
        chk("busy", 32'(dump_busy), 32'(e_busy));
        if (e_valid) begin
            chk("daddr", 32'(dump_addr), 32'(e_addr));
            chk("ddata", 32'(dump_data), 32'(e_data));
            chk("dlast", 32'(dump_last), 32'(e_last));
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && dump_busy; c++) tick();
        chk("drain_idle", 32'(dump_busy), 32'd0);
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: ADDR_W]      = ADDR_W'(a0);
        rd_addr[ADDR_W +: ADDR_W] = ADDR_W'(a1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ea [4];
        logic [DATA_W-1:0] ed [4];
        int beats;
        logic seen0;

        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        dump_start = 0; dump_base = '0; dump_len = '0; dump_ready = 0;

        // 1: reset, then every address reads zero on both ports
        tick();
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        rst = 0;
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(a, DEPTH - 1 - a);
            tick();
            chk("rst_zero", 32'(rd_data), 32'd0);
        end

        // 2: write-through on port 0, port 1 untouched
        wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; set_rd(5, 63);
        tick();
        chk("wt_rd0", 32'(rd_data[DATA_W-1:0]), 32'hBEEF);
        chk("wt_rd1", 32'(rd_data[2*DATA_W-1:DATA_W]), 32'h0);
        wr_en = 0;

        // 3: fill reg[i] = 3i and dump a wrapping burst with ready held high
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i * 3); set_rd(i, i);
            tick();
        end
        wr_en = 0;
        ea[0] = 62; ea[1] = 63; ea[2] = 0; ea[3] = 1;
        ed[0] = 16'h00BA; ed[1] = 16'h00BD; ed[2] = 16'h0000; ed[3] = 16'h0003;
        dump_start = 1; dump_base = 62; dump_len = 4; dump_ready = 1;
        tick();
        dump_start = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_valid", 32'(dump_valid), 32'd1);
            chk("t3_addr", 32'(dump_addr), 32'(ea[i]));
            chk("t3_data", 32'(dump_data), 32'(ed[i]));
            chk("t3_last", 32'(dump_last), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t3_busy_after", 32'(dump_busy), 32'd0);
        chk("t3_valid_after", 32'(dump_valid), 32'd0);

        // 4: stalls with a write to reg[0] while beat 62 is held
        dump_start = 1; dump_base = 62; dump_len = 4; dump_ready = 0;
        tick();
        dump_start = 0;
        wr_en = 1; wr_addr = 0; wr_data = 16'h1234;
        tick();
        wr_en = 0;
        chk("t4_hold_addr", 32'(dump_addr), 32'd62);
        chk("t4_hold_data", 32'(dump_data), 32'h00BA);
        tick();
        chk("t4_hold_data2", 32'(dump_data), 32'h00BA);
        seen0 = 0;
        for (int c = 0; c < 20 && dump_busy; c++) begin
            if (dump_valid && dump_addr == 0) begin
                seen0 = 1;
                chk("t4_beat0", 32'(dump_data), 32'h1234);
            end
            dump_ready = (c % 3 == 0);
            tick();
        end
        chk("t4_seen0", 32'(seen0), 32'd1);
        chk("t4_idle", 32'(dump_busy), 32'd0);

        // 5: illegal lengths, then start held high through a whole burst
        dump_start = 1; dump_base = 3; dump_len = 0;
        tick();
        chk("t5_len0_valid", 32'(dump_valid), 32'd0);
        chk("t5_len0_busy", 32'(dump_busy), 32'd0);
        dump_len = 65;
        tick();
        chk("t5_len65_valid", 32'(dump_valid), 32'd0);
        chk("t5_len65_busy", 32'(dump_busy), 32'd0);
        dump_base = 0; dump_len = 10; dump_ready = 1;
        tick();
        dump_base = 5; dump_len = 3;
        beats = 0;
        for (int c = 0; c < 30 && dump_busy; c++) begin
            if (dump_valid && dump_ready) beats++;
            tick();
        end
        dump_start = 0;
        chk("t5_beats", 32'(beats), 32'd10);
        chk("t5_idle", 32'(dump_busy), 32'd0);

        // 6: reset in the middle of a burst, restart right after
        dump_start = 1; dump_base = 0; dump_len = 10; dump_ready = 1;
        tick();
        dump_start = 0;
        tick();
        tick();
        chk("t6_beat2", 32'(dump_addr), 32'd2);
        rst = 1;
        tick();
        chk("t6_rst_valid", 32'(dump_valid), 32'd0);
        chk("t6_rst_busy", 32'(dump_busy), 32'd0);
        rst = 0;
        dump_start = 1; dump_base = 10; dump_len = 3;
        tick();
        dump_start = 0;
        chk("t6_restart", 32'(dump_valid), 32'd1);
        drain(10);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(a, a);
            tick();
            chk("t6_clear", 32'(rd_data), 32'd0);
        end

        // Random traffic on every path at once
        for (int c = 0; c < 800; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            wr_en      = $urandom_range(0, 1);
            wr_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data    = DATA_W'($urandom);
            rd_addr    = (NUM_RD*ADDR_W)'($urandom);
            if ($urandom_range(0, 3) == 0)
                rd_addr[0 +: ADDR_W] = wr_addr;
            dump_start = ($urandom_range(0, 3) == 0);
            dump_base  = ADDR_W'($urandom_range(0, DEPTH - 1));
            dump_len   = (ADDR_W+1)'($urandom_range(0, 70));
            dump_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 0; wr_en = 0; dump_start = 0; dump_ready = 1;
        drain(DEPTH + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
